// File: rtl/instr_field_decoder.sv
// Byte-serial x86-subset instruction field decoder: assembles opcode, ModR/M,
// displacement and immediate, then holds them for a valid/ready consumer.
module instr_field_decoder (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  opcode,
  output logic [7:0]  modrm,
  output logic [31:0] disp,
  output logic [31:0] imm,
  output logic        has_modrm,
  output logic [1:0]  disp_sz,
  output logic [1:0]  imm_sz,
  output logic [3:0]  len,
  output logic        illegal
);

  typedef enum logic [2:0] {OPC, MODRM, DISP, IMM, OUT} state_t;

  state_t      state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [7:0]  opcode_nx, modrm_nx;
  logic [31:0] disp_nx, imm_nx;
  logic        has_modrm_nx, illegal_nx;
  logic [1:0]  disp_sz_nx, imm_sz_nx;
  logic [3:0]  len_nx;

  logic       take;
  logic [1:0] mod_f;
  logic [2:0] reg_f, rm_f;
  logic       reg_bad;

  assign take  = in_valid & in_ready;
  assign mod_f = in_byte[7:6];
  assign reg_f = in_byte[5:3];
  assign rm_f  = in_byte[2:0];
  assign reg_bad = ((opcode == 8'h83) && (reg_f > 3'd1)) ||
                   ((opcode == 8'hC1) && (reg_f != 3'd5)) ||
                   ((opcode == 8'hFF) && (reg_f != 3'd4));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= OPC;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    opcode_nx    = opcode;
    modrm_nx     = modrm;
    disp_nx      = disp;
    imm_nx       = imm;
    has_modrm_nx = has_modrm;
    disp_sz_nx   = disp_sz;
    imm_sz_nx    = imm_sz;
    len_nx       = len;
    illegal_nx   = illegal;
    // flush outranks a coincident out_ready; both end in a cleared OPC
    if (flush || (state == OUT && out_ready)) begin
      state_nx     = OPC;
      cnt_nx       = '0;
      opcode_nx    = '0;
      modrm_nx     = '0;
      disp_nx      = '0;
      imm_nx       = '0;
      has_modrm_nx = 1'b0;
      disp_sz_nx   = '0;
      imm_sz_nx    = '0;
      len_nx       = '0;
      illegal_nx   = 1'b0;
    end else if (take) begin
      unique case (state)
        OPC: begin
          opcode_nx = in_byte;
          len_nx    = 4'd1;
          case (in_byte)
            8'h01, 8'h09, 8'hFF: has_modrm_nx = 1'b1;
            8'h05, 8'h0D:        imm_sz_nx    = 2'b10;
            8'h83, 8'hC1: begin
              has_modrm_nx = 1'b1;
              imm_sz_nx    = 2'b01;
            end
            8'hEB:   disp_sz_nx = 2'b01;
            8'hE9:   disp_sz_nx = 2'b10;
            default: illegal_nx = 1'b1;
          endcase
          if (illegal_nx)           state_nx = OUT;
          else if (has_modrm_nx)    state_nx = MODRM;
          else if (disp_sz_nx != 0) state_nx = DISP;
          else if (imm_sz_nx != 0)  state_nx = IMM;
          else                      state_nx = OUT;
        end
        MODRM: begin
          modrm_nx = in_byte;
          len_nx   = len + 4'd1;
          if (mod_f != 2'b11 && rm_f == 3'b100) begin
            illegal_nx = 1'b1;
            state_nx   = OUT;
          end else begin
            if (mod_f == 2'b00 && rm_f == 3'b101) disp_sz_nx = 2'b10;
            else if (mod_f == 2'b01)              disp_sz_nx = 2'b01;
            else if (mod_f == 2'b10)              disp_sz_nx = 2'b10;
            else                                  disp_sz_nx = 2'b00;
            // bad /reg is only flagged; remaining fields are still consumed
            if (reg_bad) illegal_nx = 1'b1;
            if (disp_sz_nx != 0)  state_nx = DISP;
            else if (imm_sz != 0) state_nx = IMM;
            else                  state_nx = OUT;
          end
        end
        DISP: begin
          len_nx = len + 4'd1;
          if (disp_sz == 2'b01) disp_nx = {in_byte, 24'h0};
          else                  disp_nx[{cnt, 3'b000} +: 8] = in_byte;
          if (disp_sz == 2'b01 || cnt == 2'd3) begin
            cnt_nx   = '0;
            state_nx = (imm_sz != 0) ? IMM : OUT;
          end else begin
            cnt_nx = cnt + 2'd1;
          end
        end
        IMM: begin
          len_nx = len + 4'd1;
          if (imm_sz == 2'b01) imm_nx = {in_byte, 24'h0};
          else                 imm_nx[{cnt, 3'b000} +: 8] = in_byte;
          if (imm_sz == 2'b01 || cnt == 2'd3) begin
            cnt_nx   = '0;
            state_nx = OUT;
          end else begin
            cnt_nx = cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt       <= '0;
      opcode    <= '0;
      modrm     <= '0;
      disp      <= '0;
      imm       <= '0;
      has_modrm <= 1'b0;
      disp_sz   <= '0;
      imm_sz    <= '0;
      len       <= '0;
      illegal   <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      opcode    <= opcode_nx;
      modrm     <= modrm_nx;
      disp      <= disp_nx;
      imm       <= imm_nx;
      has_modrm <= has_modrm_nx;
      disp_sz   <= disp_sz_nx;
      imm_sz    <= imm_sz_nx;
      len       <= len_nx;
      illegal   <= illegal_nx;
    end
  end

  always_comb begin
    in_ready  = clr && (state != OUT);
    out_valid = (state == OUT);
  end

endmodule

// File: tb/tb_instr_field_decoder.sv
// Table-driven bench for instr_field_decoder with an expected-result queue.
module tb_instr_field_decoder;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  in_byte = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  opcode, modrm;
  logic [31:0] disp, imm;
  logic        has_modrm, illegal;
  logic [1:0]  disp_sz, imm_sz;
  logic [3:0]  len;

  instr_field_decoder dut (
    .clk(clk), .clr(clr), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .modrm(modrm), .disp(disp),
    .imm(imm), .has_modrm(has_modrm), .disp_sz(disp_sz), .imm_sz(imm_sz),
    .len(len), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] b;   // byte i at [8*i +: 8]
    int          n;
    logic [7:0]  op, mr;
    logic [31:0] dp, im;
    logic        hm;
    logic [1:0]  dsz, isz;
    logic [3:0]  ln;
    logic        ill;
  } vec_t;

  vec_t vecs[15];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic [79:0] b, input int n,
                              input logic [7:0] op, input logic [7:0] mr,
                              input logic [31:0] dp, input logic [31:0] im,
                              input logic hm, input logic [1:0] dsz,
                              input logic [1:0] isz, input logic [3:0] ln,
                              input logic ill);
    vec_t v;
    v.b = b; v.n = n; v.op = op; v.mr = mr; v.dp = dp; v.im = im;
    v.hm = hm; v.dsz = dsz; v.isz = isz; v.ln = ln; v.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic get_out(input bit hold3);
    vec_t e;
    int t = 0;
    @(negedge clk);
    while (!out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid || sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL out_valid_timeout: got %0b expected 1 (queued %0d)", out_valid, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk("opcode",    {24'h0, opcode},    {24'h0, e.op});
    chk("modrm",     {24'h0, modrm},     {24'h0, e.mr});
    chk("disp",      disp,               e.dp);
    chk("imm",       imm,                e.im);
    chk("has_modrm", {31'h0, has_modrm}, {31'h0, e.hm});
    chk("disp_sz",   {30'h0, disp_sz},   {30'h0, e.dsz});
    chk("imm_sz",    {30'h0, imm_sz},    {30'h0, e.isz});
    chk("len",       {28'h0, len},       {28'h0, e.ln});
    chk("illegal",   {31'h0, illegal},   {31'h0, e.ill});
    chk("in_ready_in_out", {31'h0, in_ready}, 32'h0);
    if (hold3) begin
      repeat (3) begin
        @(negedge clk);
        chk("hold_out_valid", {31'h0, out_valid}, 32'h1);
        chk("hold_in_ready",  {31'h0, in_ready},  32'h0);
        chk("hold_disp",      disp,               e.dp);
        chk("hold_len",       {28'h0, len},       {28'h0, e.ln});
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("post_in_ready",  {31'h0, in_ready},  32'h1);
    chk("post_out_valid", {31'h0, out_valid}, 32'h0);
    chk("post_len",       {28'h0, len},       32'h0);
    chk("post_opcode",    {24'h0, opcode},    32'h0);
  endtask

  task automatic run_vec(input vec_t v, input bit gaps, input bit hold3);
    sb.push_back(v);
    for (int i = 0; i < v.n; i++) begin
      if (i == v.n - 1) chk("early_out_valid", {31'h0, out_valid}, 32'h0);
      send(v.b[8*i +: 8], gaps ? int'($urandom_range(0, 2)) : 0);
    end
    get_out(hold3);
  endtask

  task automatic chk_cleared(input string name);
    chk({name, "_opcode"},    {24'h0, opcode},    32'h0);
    chk({name, "_disp"},      disp,               32'h0);
    chk({name, "_imm"},       imm,                32'h0);
    chk({name, "_len"},       {28'h0, len},       32'h0);
    chk({name, "_out_valid"}, {31'h0, out_valid}, 32'h0);
  endtask

  initial begin
    vecs[0]  = mk(80'h05C083,         3, 8'h83, 8'hC0, 32'h0,        32'h05000000, 1, 2'b00, 2'b01, 4'd3, 0);
    vecs[1]  = mk(80'hF84501,         3, 8'h01, 8'h45, 32'hF8000000, 32'h0,        1, 2'b01, 2'b00, 4'd3, 0);
    vecs[2]  = mk(80'h112233440509,   6, 8'h09, 8'h05, 32'h11223344, 32'h0,        1, 2'b10, 2'b00, 4'd6, 0);
    vecs[3]  = mk(80'h1234567805,     5, 8'h05, 8'h00, 32'h0,        32'h12345678, 0, 2'b00, 2'b10, 4'd5, 0);
    vecs[4]  = mk(80'h04E8C1,         3, 8'hC1, 8'hE8, 32'h0,        32'h04000000, 1, 2'b00, 2'b01, 4'd3, 0);
    vecs[5]  = mk(80'h0F,             1, 8'h0F, 8'h00, 32'h0,        32'h0,        0, 2'b00, 2'b00, 4'd1, 1);
    vecs[6]  = mk(80'h0401,           2, 8'h01, 8'h04, 32'h0,        32'h0,        1, 2'b00, 2'b00, 4'd2, 1);
    vecs[7]  = mk(80'h07D083,         3, 8'h83, 8'hD0, 32'h0,        32'h07000000, 1, 2'b00, 2'b01, 4'd3, 1);
    vecs[8]  = mk(80'h10EB,           2, 8'hEB, 8'h00, 32'h10000000, 32'h0,        0, 2'b01, 2'b00, 4'd2, 0);
    vecs[9]  = mk(80'h00000010E9,     5, 8'hE9, 8'h00, 32'h00000010, 32'h0,        0, 2'b10, 2'b00, 4'd5, 0);
    vecs[10] = mk(80'h7C60FF,         3, 8'hFF, 8'h60, 32'h7C000000, 32'h0,        1, 2'b01, 2'b00, 4'd3, 0);
    vecs[11] = mk(80'h05123456788883, 7, 8'h83, 8'h88, 32'h12345678, 32'h05000000, 1, 2'b10, 2'b01, 4'd7, 0);
    vecs[12] = mk(80'h040302010D,     5, 8'h0D, 8'h00, 32'h0,        32'h04030201, 0, 2'b00, 2'b10, 4'd5, 0);
    vecs[13] = mk(80'hC801,           2, 8'h01, 8'hC8, 32'h0,        32'h0,        1, 2'b00, 2'b00, 4'd2, 0);
    vecs[14] = mk(80'h24FF,           2, 8'hFF, 8'h24, 32'h0,        32'h0,        1, 2'b00, 2'b00, 4'd2, 1);

    #2 chk_cleared("reset");
    #10 clr = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) run_vec(vecs[i], 1'b1, 1'b0);

    // consumer stalls for three cycles with the jump held
    run_vec(vecs[9], 1'b0, 1'b1);

    // async reset mid-instruction
    send(8'hE9, 0);
    send(8'h78, 0);
    #2 clr = 1'b0;
    #1 chk_cleared("clr");
    #3 clr = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", {31'h0, in_ready}, 32'h1);
    run_vec(vecs[8], 1'b0, 1'b0);

    // flush of a partial instruction
    send(8'h05, 0);
    send(8'h11, 0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk_cleared("flush");
    repeat (3) begin
      @(negedge clk);
      chk("flush_no_out", {31'h0, out_valid}, 32'h0);
    end
    run_vec(vecs[13], 1'b0, 1'b0);

    // flush while holding, coincident with out_ready
    send(8'h0F, 0);
    @(negedge clk);
    chk("flush_out_hold", {31'h0, out_valid}, 32'h1);
    flush = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 begin flush = 1'b0; out_ready = 1'b0; end
    @(negedge clk);
    chk_cleared("flush_out");
    chk("flush_out_in_ready", {31'h0, in_ready}, 32'h1);
    run_vec(vecs[0], 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
